axi_reg_array: RTL and testbench

//  Parametrised AXI4 pipeline slice between s_axi and m_axi: per-channel selectable register mode, chained depth.

---
 rtl/axi_reg_array_pkg.sv | 13 +
 rtl/axi_reg_stage.sv | 81 ++++++++
 rtl/axi_reg_array.sv | 210 +++++++++++++++++++++
 tb/tb_axi_reg_array.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_reg_array_pkg.sv
// axi_reg_array_pkg: register-slice mode encodings and shared AXI field widths
package axi_reg_array_pkg;

    localparam int REG_BYPASS = 0;
    localparam int REG_LIGHT  = 1;
    localparam int REG_FULL   = 2;

    // len(8) + size(3) + burst(2) + lock(1) + cache(4) + prot(3) + qos(4) + region(4)
    localparam int AX_CTRL_BITS = 29;

    typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} skid_state_e;

endpackage

// File: rtl/axi_reg_stage.sv
// axi_reg_stage: one valid/ready register slice, LIGHT (single entry) or FULL (main + skid)
module axi_reg_stage
    import axi_reg_array_pkg::*;
#(
    parameter int DATA_BITS = 32,
    parameter int MODE      = REG_FULL
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DATA_BITS-1:0] s_data_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [DATA_BITS-1:0] m_data_o
);

    if (MODE == REG_LIGHT) begin : g_light
        logic                 full_q, full_d, rdy_q, push, pop;
        logic [DATA_BITS-1:0] data_q;
        assign push      = s_valid_i && rdy_q;
        assign pop       = full_q && m_ready_i;
        assign full_d    = push || (full_q && !pop);
        assign s_ready_o = rdy_q;
        assign m_valid_o = full_q;
        assign m_data_o  = data_q;
        // occupancy and registered ready; ready stays low for the cycle after a push
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                full_q <= 1'b0;
                rdy_q  <= 1'b0;
            end else begin
                full_q <= full_d;
                rdy_q  <= !full_d;
            end
        end
        // payload capture, not reset
        always_ff @(posedge aclk) begin
            if (push) data_q <= s_data_i;
        end
    end else begin : g_full
        skid_state_e          state_q, state_d;
        logic                 rdy_q, push, pop;
        logic [DATA_BITS-1:0] main_q, skid_q;
        assign push      = s_valid_i && rdy_q;
        assign pop       = (state_q != ST_EMPTY) && m_ready_i;
        assign s_ready_o = rdy_q;
        assign m_valid_o = state_q != ST_EMPTY;
        assign m_data_o  = main_q;
        // next occupancy state from push/pop
        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_EMPTY: state_d = push ? ST_BUSY : ST_EMPTY;
                ST_BUSY:  state_d = (push && !pop) ? ST_FULL : (pop && !push) ? ST_EMPTY : ST_BUSY;
                ST_FULL:  state_d = pop ? ST_BUSY : ST_FULL;
                default:  state_d = ST_EMPTY;
            endcase
        end
        // state register; ready registered from whether the skid will be occupied
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                state_q <= ST_EMPTY;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                rdy_q   <= state_d != ST_FULL;
            end
        end
        // main reloads from skid when draining FULL, else from upstream; skid catches a stalled push
        always_ff @(posedge aclk) begin
            if (state_q == ST_FULL) begin
                if (pop) main_q <= skid_q;
            end else if (push && (state_q == ST_EMPTY || pop)) begin
                main_q <= s_data_i;
            end
            if (push && state_q == ST_BUSY && !pop) skid_q <= s_data_i;
        end
    end

endmodule

// File: rtl/axi_reg_array.sv
// axi_reg_array: AXI4 pipeline slice with per-channel mode and N_STAGES chained slices
module axi_reg_array
    import axi_reg_array_pkg::*;
#(
    parameter int AXI_DATA_BITS = 512,
    parameter int AXI_ADDR_BITS = 64,
    parameter int AXI_ID_BITS   = 6,
    parameter int N_STAGES      = 1,
    parameter int AW_MODE       = REG_FULL,
    parameter int W_MODE        = REG_FULL,
    parameter int B_MODE        = REG_FULL,
    parameter int AR_MODE       = REG_FULL,
    parameter int R_MODE        = REG_FULL
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [AXI_ID_BITS-1:0]     s_axi_awid_i,
    input  logic [AXI_ADDR_BITS-1:0]   s_axi_awaddr_i,
    input  logic [7:0]                 s_axi_awlen_i,
    input  logic [2:0]                 s_axi_awsize_i,
    input  logic [1:0]                 s_axi_awburst_i,
    input  logic                       s_axi_awlock_i,
    input  logic [3:0]                 s_axi_awcache_i,
    input  logic [2:0]                 s_axi_awprot_i,
    input  logic [3:0]                 s_axi_awqos_i,
    input  logic [3:0]                 s_axi_awregion_i,
    input  logic                       s_axi_awvalid_i,
    output logic                       s_axi_awready_o,
    output logic [AXI_ID_BITS-1:0]     m_axi_awid_o,
    output logic [AXI_ADDR_BITS-1:0]   m_axi_awaddr_o,
    output logic [7:0]                 m_axi_awlen_o,
    output logic [2:0]                 m_axi_awsize_o,
    output logic [1:0]                 m_axi_awburst_o,
    output logic                       m_axi_awlock_o,
    output logic [3:0]                 m_axi_awcache_o,
    output logic [2:0]                 m_axi_awprot_o,
    output logic [3:0]                 m_axi_awqos_o,
    output logic [3:0]                 m_axi_awregion_o,
    output logic                       m_axi_awvalid_o,
    input  logic                       m_axi_awready_i,
    input  logic [AXI_DATA_BITS-1:0]   s_axi_wdata_i,
    input  logic [AXI_DATA_BITS/8-1:0] s_axi_wstrb_i,
    input  logic                       s_axi_wlast_i,
    input  logic                       s_axi_wvalid_i,
    output logic                       s_axi_wready_o,
    output logic [AXI_DATA_BITS-1:0]   m_axi_wdata_o,
    output logic [AXI_DATA_BITS/8-1:0] m_axi_wstrb_o,
    output logic                       m_axi_wlast_o,
    output logic                       m_axi_wvalid_o,
    input  logic                       m_axi_wready_i,
    input  logic [AXI_ID_BITS-1:0]     m_axi_bid_i,
    input  logic [1:0]                 m_axi_bresp_i,
    input  logic                       m_axi_bvalid_i,
    output logic                       m_axi_bready_o,
    output logic [AXI_ID_BITS-1:0]     s_axi_bid_o,
    output logic [1:0]                 s_axi_bresp_o,
    output logic                       s_axi_bvalid_o,
    input  logic                       s_axi_bready_i,
    input  logic [AXI_ID_BITS-1:0]     s_axi_arid_i,
    input  logic [AXI_ADDR_BITS-1:0]   s_axi_araddr_i,
    input  logic [7:0]                 s_axi_arlen_i,
    input  logic [2:0]                 s_axi_arsize_i,
    input  logic [1:0]                 s_axi_arburst_i,
    input  logic                       s_axi_arlock_i,
    input  logic [3:0]                 s_axi_arcache_i,
    input  logic [2:0]                 s_axi_arprot_i,
    input  logic [3:0]                 s_axi_arqos_i,
    input  logic [3:0]                 s_axi_arregion_i,
    input  logic                       s_axi_arvalid_i,
    output logic                       s_axi_arready_o,
    output logic [AXI_ID_BITS-1:0]     m_axi_arid_o,
    output logic [AXI_ADDR_BITS-1:0]   m_axi_araddr_o,
    output logic [7:0]                 m_axi_arlen_o,
    output logic [2:0]                 m_axi_arsize_o,
    output logic [1:0]                 m_axi_arburst_o,
    output logic                       m_axi_arlock_o,
    output logic [3:0]                 m_axi_arcache_o,
    output logic [2:0]                 m_axi_arprot_o,
    output logic [3:0]                 m_axi_arqos_o,
    output logic [3:0]                 m_axi_arregion_o,
    output logic                       m_axi_arvalid_o,
    input  logic                       m_axi_arready_i,
    input  logic [AXI_ID_BITS-1:0]     m_axi_rid_i,
    input  logic [AXI_DATA_BITS-1:0]   m_axi_rdata_i,
    input  logic [1:0]                 m_axi_rresp_i,
    input  logic                       m_axi_rlast_i,
    input  logic                       m_axi_rvalid_i,
    output logic                       m_axi_rready_o,
    output logic [AXI_ID_BITS-1:0]     s_axi_rid_o,
    output logic [AXI_DATA_BITS-1:0]   s_axi_rdata_o,
    output logic [1:0]                 s_axi_rresp_o,
    output logic                       s_axi_rlast_o,
    output logic                       s_axi_rvalid_o,
    input  logic                       s_axi_rready_i
);

    localparam int AX_W = AXI_ID_BITS + AXI_ADDR_BITS + AX_CTRL_BITS;
    localparam int W_W  = AXI_DATA_BITS + AXI_DATA_BITS / 8 + 1;
    localparam int B_W  = AXI_ID_BITS + 2;
    localparam int R_W  = AXI_ID_BITS + AXI_DATA_BITS + 3;

    // Index 0 is the channel's upstream end, index N_STAGES its downstream end.
    logic [AX_W-1:0] aw_d [N_STAGES+1];
    logic [W_W-1:0]  w_d  [N_STAGES+1];
    logic [B_W-1:0]  b_d  [N_STAGES+1];
    logic [AX_W-1:0] ar_d [N_STAGES+1];
    logic [R_W-1:0]  r_d  [N_STAGES+1];
    logic [N_STAGES:0] aw_v, aw_r, w_v, w_r, b_v, b_r, ar_v, ar_r, r_v, r_r;

    assign aw_d[0] = {s_axi_awid_i, s_axi_awaddr_i, s_axi_awlen_i, s_axi_awsize_i, s_axi_awburst_i,
                      s_axi_awlock_i, s_axi_awcache_i, s_axi_awprot_i, s_axi_awqos_i, s_axi_awregion_i};
    assign {m_axi_awid_o, m_axi_awaddr_o, m_axi_awlen_o, m_axi_awsize_o, m_axi_awburst_o,
            m_axi_awlock_o, m_axi_awcache_o, m_axi_awprot_o, m_axi_awqos_o, m_axi_awregion_o} = aw_d[N_STAGES];
    assign aw_v[0]            = s_axi_awvalid_i;
    assign s_axi_awready_o    = aw_r[0];
    assign m_axi_awvalid_o    = aw_v[N_STAGES];
    assign aw_r[N_STAGES]     = m_axi_awready_i;

    assign w_d[0] = {s_axi_wdata_i, s_axi_wstrb_i, s_axi_wlast_i};
    assign {m_axi_wdata_o, m_axi_wstrb_o, m_axi_wlast_o} = w_d[N_STAGES];
    assign w_v[0]             = s_axi_wvalid_i;
    assign s_axi_wready_o     = w_r[0];
    assign m_axi_wvalid_o     = w_v[N_STAGES];
    assign w_r[N_STAGES]      = m_axi_wready_i;

    assign b_d[0] = {m_axi_bid_i, m_axi_bresp_i};
    assign {s_axi_bid_o, s_axi_bresp_o} = b_d[N_STAGES];
    assign b_v[0]             = m_axi_bvalid_i;
    assign m_axi_bready_o     = b_r[0];
    assign s_axi_bvalid_o     = b_v[N_STAGES];
    assign b_r[N_STAGES]      = s_axi_bready_i;

    assign ar_d[0] = {s_axi_arid_i, s_axi_araddr_i, s_axi_arlen_i, s_axi_arsize_i, s_axi_arburst_i,
                      s_axi_arlock_i, s_axi_arcache_i, s_axi_arprot_i, s_axi_arqos_i, s_axi_arregion_i};
    assign {m_axi_arid_o, m_axi_araddr_o, m_axi_arlen_o, m_axi_arsize_o, m_axi_arburst_o,
            m_axi_arlock_o, m_axi_arcache_o, m_axi_arprot_o, m_axi_arqos_o, m_axi_arregion_o} = ar_d[N_STAGES];
    assign ar_v[0]            = s_axi_arvalid_i;
    assign s_axi_arready_o    = ar_r[0];
    assign m_axi_arvalid_o    = ar_v[N_STAGES];
    assign ar_r[N_STAGES]     = m_axi_arready_i;

    assign r_d[0] = {m_axi_rid_i, m_axi_rdata_i, m_axi_rresp_i, m_axi_rlast_i};
    assign {s_axi_rid_o, s_axi_rdata_o, s_axi_rresp_o, s_axi_rlast_o} = r_d[N_STAGES];
    assign r_v[0]             = m_axi_rvalid_i;
    assign m_axi_rready_o     = r_r[0];
    assign s_axi_rvalid_o     = r_v[N_STAGES];
    assign r_r[N_STAGES]      = s_axi_rready_i;

    // Bypass stages are plain wires so no clocked logic exists on that channel.
    for (genvar k = 0; k < N_STAGES; k++) begin : g_aw
        if (AW_MODE == REG_BYPASS) begin : g_wire
            assign aw_v[k+1] = aw_v[k];
            assign aw_d[k+1] = aw_d[k];
            assign aw_r[k]   = aw_r[k+1];
        end else begin : g_reg
            axi_reg_stage #(.DATA_BITS(AX_W), .MODE(AW_MODE)) u_stage (
                .aclk, .areset, .s_valid_i(aw_v[k]), .s_ready_o(aw_r[k]), .s_data_i(aw_d[k]),
                .m_valid_o(aw_v[k+1]), .m_ready_i(aw_r[k+1]), .m_data_o(aw_d[k+1]));
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_w
        if (W_MODE == REG_BYPASS) begin : g_wire
            assign w_v[k+1] = w_v[k];
            assign w_d[k+1] = w_d[k];
            assign w_r[k]   = w_r[k+1];
        end else begin : g_reg
            axi_reg_stage #(.DATA_BITS(W_W), .MODE(W_MODE)) u_stage (
                .aclk, .areset, .s_valid_i(w_v[k]), .s_ready_o(w_r[k]), .s_data_i(w_d[k]),
                .m_valid_o(w_v[k+1]), .m_ready_i(w_r[k+1]), .m_data_o(w_d[k+1]));
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_b
        if (B_MODE == REG_BYPASS) begin : g_wire
            assign b_v[k+1] = b_v[k];
            assign b_d[k+1] = b_d[k];
            assign b_r[k]   = b_r[k+1];
        end else begin : g_reg
            axi_reg_stage #(.DATA_BITS(B_W), .MODE(B_MODE)) u_stage (
                .aclk, .areset, .s_valid_i(b_v[k]), .s_ready_o(b_r[k]), .s_data_i(b_d[k]),
                .m_valid_o(b_v[k+1]), .m_ready_i(b_r[k+1]), .m_data_o(b_d[k+1]));
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_ar
        if (AR_MODE == REG_BYPASS) begin : g_wire
            assign ar_v[k+1] = ar_v[k];
            assign ar_d[k+1] = ar_d[k];
            assign ar_r[k]   = ar_r[k+1];
        end else begin : g_reg
            axi_reg_stage #(.DATA_BITS(AX_W), .MODE(AR_MODE)) u_stage (
                .aclk, .areset, .s_valid_i(ar_v[k]), .s_ready_o(ar_r[k]), .s_data_i(ar_d[k]),
                .m_valid_o(ar_v[k+1]), .m_ready_i(ar_r[k+1]), .m_data_o(ar_d[k+1]));
        end
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_r
        if (R_MODE == REG_BYPASS) begin : g_wire
            assign r_v[k+1] = r_v[k];
            assign r_d[k+1] = r_d[k];
            assign r_r[k]   = r_r[k+1];
        end else begin : g_reg
            axi_reg_stage #(.DATA_BITS(R_W), .MODE(R_MODE)) u_stage (
                .aclk, .areset, .s_valid_i(r_v[k]), .s_ready_o(r_r[k]), .s_data_i(r_d[k]),
                .m_valid_o(r_v[k+1]), .m_ready_i(r_r[k+1]), .m_data_o(r_d[k+1]));
        end
    end

endmodule

// File: tb/tb_axi_reg_array.sv
// tb_axi_reg_array: randomized scoreboard bench for axi_reg_array with mixed channel modes
module tb_axi_reg_array;

    localparam int DB = 64, AB = 32, IB = 4, N = 2;
    localparam int BYP = 0, LGT = 1, FUL = 2;
    localparam int AX_W = IB + AB + 29, W_W = DB + DB / 8 + 1, B_W = IB + 2, R_W = IB + DB + 3;
    localparam int PW = W_W;
    typedef logic [PW-1:0] pl_t;

    // channel order: AW, W, B, AR, R
    localparam int MD [5] = '{FUL, FUL, BYP, LGT, FUL};
    string nm  [5] = '{"aw", "w", "b", "ar", "r"};
    int    wid [5] = '{AX_W, W_W, B_W, AX_W, R_W};

    logic clk, areset;
    logic src_v [5], sink_r [5], dut_v [5], dut_r [5];
    pl_t  src_d [5], dut_d [5];

    logic [IB-1:0] s_awid, m_awid, s_arid, m_arid, s_bid, m_bid, s_rid, m_rid;
    logic [AB-1:0] s_awaddr, m_awaddr, s_araddr, m_araddr;
    logic [7:0]    s_awlen, m_awlen, s_arlen, m_arlen;
    logic [2:0]    s_awsize, m_awsize, s_arsize, m_arsize, s_awprot, m_awprot, s_arprot, m_arprot;
    logic [1:0]    s_awburst, m_awburst, s_arburst, m_arburst, s_bresp, m_bresp, s_rresp, m_rresp;
    logic          s_awlock, m_awlock, s_arlock, m_arlock;
    logic [3:0]    s_awcache, m_awcache, s_arcache, m_arcache, s_awqos, m_awqos, s_arqos, m_arqos;
    logic [3:0]    s_awregion, m_awregion, s_arregion, m_arregion;
    logic [DB-1:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [DB/8-1:0] s_wstrb, m_wstrb;
    logic          s_wlast, m_wlast, s_rlast, m_rlast;
    logic s_awvalid, s_awready, m_awvalid, m_awready, s_wvalid, s_wready, m_wvalid, m_wready;
    logic s_bvalid, s_bready, m_bvalid, m_bready, s_arvalid, s_arready, m_arvalid, m_arready;
    logic s_rvalid, s_rready, m_rvalid, m_rready;

    assign {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos, s_awregion} = src_d[0][AX_W-1:0];
    assign dut_d[0] = PW'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock, m_awcache, m_awprot, m_awqos, m_awregion});
    assign {s_wdata, s_wstrb, s_wlast} = src_d[1][W_W-1:0];
    assign dut_d[1] = PW'({m_wdata, m_wstrb, m_wlast});
    assign {m_bid, m_bresp} = src_d[2][B_W-1:0];
    assign dut_d[2] = PW'({s_bid, s_bresp});
    assign {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arregion} = src_d[3][AX_W-1:0];
    assign dut_d[3] = PW'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock, m_arcache, m_arprot, m_arqos, m_arregion});
    assign {m_rid, m_rdata, m_rresp, m_rlast} = src_d[4][R_W-1:0];
    assign dut_d[4] = PW'({s_rid, s_rdata, s_rresp, s_rlast});

    assign s_awvalid = src_v[0]; assign m_awready = sink_r[0]; assign dut_v[0] = m_awvalid; assign dut_r[0] = s_awready;
    assign s_wvalid  = src_v[1]; assign m_wready  = sink_r[1]; assign dut_v[1] = m_wvalid;  assign dut_r[1] = s_wready;
    assign m_bvalid  = src_v[2]; assign s_bready  = sink_r[2]; assign dut_v[2] = s_bvalid;  assign dut_r[2] = m_bready;
    assign s_arvalid = src_v[3]; assign m_arready = sink_r[3]; assign dut_v[3] = m_arvalid; assign dut_r[3] = s_arready;
    assign m_rvalid  = src_v[4]; assign s_rready  = sink_r[4]; assign dut_v[4] = s_rvalid;  assign dut_r[4] = m_rready;

    axi_reg_array #(
        .AXI_DATA_BITS(DB), .AXI_ADDR_BITS(AB), .AXI_ID_BITS(IB), .N_STAGES(N),
        .AW_MODE(MD[0]), .W_MODE(MD[1]), .B_MODE(MD[2]), .AR_MODE(MD[3]), .R_MODE(MD[4])
    ) dut (
        .aclk(clk), .areset(areset),
        .s_axi_awid_i(s_awid), .s_axi_awaddr_i(s_awaddr), .s_axi_awlen_i(s_awlen), .s_axi_awsize_i(s_awsize),
        .s_axi_awburst_i(s_awburst), .s_axi_awlock_i(s_awlock), .s_axi_awcache_i(s_awcache), .s_axi_awprot_i(s_awprot),
        .s_axi_awqos_i(s_awqos), .s_axi_awregion_i(s_awregion), .s_axi_awvalid_i(s_awvalid), .s_axi_awready_o(s_awready),
        .m_axi_awid_o(m_awid), .m_axi_awaddr_o(m_awaddr), .m_axi_awlen_o(m_awlen), .m_axi_awsize_o(m_awsize),
        .m_axi_awburst_o(m_awburst), .m_axi_awlock_o(m_awlock), .m_axi_awcache_o(m_awcache), .m_axi_awprot_o(m_awprot),
        .m_axi_awqos_o(m_awqos), .m_axi_awregion_o(m_awregion), .m_axi_awvalid_o(m_awvalid), .m_axi_awready_i(m_awready),
        .s_axi_wdata_i(s_wdata), .s_axi_wstrb_i(s_wstrb), .s_axi_wlast_i(s_wlast), .s_axi_wvalid_i(s_wvalid),
        .s_axi_wready_o(s_wready), .m_axi_wdata_o(m_wdata), .m_axi_wstrb_o(m_wstrb), .m_axi_wlast_o(m_wlast),
        .m_axi_wvalid_o(m_wvalid), .m_axi_wready_i(m_wready),
        .m_axi_bid_i(m_bid), .m_axi_bresp_i(m_bresp), .m_axi_bvalid_i(m_bvalid), .m_axi_bready_o(m_bready),
        .s_axi_bid_o(s_bid), .s_axi_bresp_o(s_bresp), .s_axi_bvalid_o(s_bvalid), .s_axi_bready_i(s_bready),
        .s_axi_arid_i(s_arid), .s_axi_araddr_i(s_araddr), .s_axi_arlen_i(s_arlen), .s_axi_arsize_i(s_arsize),
        .s_axi_arburst_i(s_arburst), .s_axi_arlock_i(s_arlock), .s_axi_arcache_i(s_arcache), .s_axi_arprot_i(s_arprot),
        .s_axi_arqos_i(s_arqos), .s_axi_arregion_i(s_arregion), .s_axi_arvalid_i(s_arvalid), .s_axi_arready_o(s_arready),
        .m_axi_arid_o(m_arid), .m_axi_araddr_o(m_araddr), .m_axi_arlen_o(m_arlen), .m_axi_arsize_o(m_arsize),
        .m_axi_arburst_o(m_arburst), .m_axi_arlock_o(m_arlock), .m_axi_arcache_o(m_arcache), .m_axi_arprot_o(m_arprot),
        .m_axi_arqos_o(m_arqos), .m_axi_arregion_o(m_arregion), .m_axi_arvalid_o(m_arvalid), .m_axi_arready_i(m_arready),
        .m_axi_rid_i(m_rid), .m_axi_rdata_i(m_rdata), .m_axi_rresp_i(m_rresp), .m_axi_rlast_i(m_rlast),
        .m_axi_rvalid_i(m_rvalid), .m_axi_rready_o(m_rready),
        .s_axi_rid_o(s_rid), .s_axi_rdata_o(s_rdata), .s_axi_rresp_o(s_rresp), .s_axi_rlast_o(s_rlast),
        .s_axi_rvalid_o(s_rvalid), .s_axi_rready_i(s_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: per-channel FIFO of accepted beats plus their acceptance cycle
    pl_t  exp_q [5][$];
    int   ts_q  [5][$];
    logic held_v [5], fin [5], last_r [5];
    pl_t  held_d [5];
    int   acc [5], out_n [5];
    int   n_tests = 0, n_fail = 0, cyc = 0;
    bit   chk_lat = 1'b0;

    task automatic check(string tag, pl_t got, pl_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic pl_t rnd_pl(int c);
        pl_t p;
        p = PW'({$urandom, $urandom, $urandom});
        return p & ((PW'(1) << wid[c]) - PW'(1));
    endfunction

    function automatic int lat_of(int c);
        return MD[c] == BYP ? 0 : N;
    endfunction

    function automatic int cap_of(int c);
        return MD[c] == FUL ? 2 * N : MD[c] == LGT ? N : 0;
    endfunction

    // evaluate handshakes just before the coming edge, then advance one cycle
    task automatic step();
        int t;
        #1;
        for (int c = 0; c < 5; c++) begin
            last_r[c] = dut_r[c];
            if (MD[c] == BYP) begin
                check({nm[c], "_wire_vr"}, PW'({dut_v[c], dut_r[c]}), PW'({src_v[c], sink_r[c]}));
                check({nm[c], "_wire_d"}, dut_d[c], src_d[c]);
            end else if (held_v[c]) begin
                check({nm[c], "_hold_v"}, PW'(dut_v[c]), PW'(1));
                check({nm[c], "_hold_d"}, dut_d[c], held_d[c]);
            end
            fin[c] = src_v[c] && dut_r[c];
            if (fin[c]) begin
                exp_q[c].push_back(src_d[c]);
                ts_q[c].push_back(cyc);
                acc[c]++;
            end
            if (dut_v[c] && sink_r[c]) begin
                out_n[c]++;
                if (exp_q[c].size() == 0) begin
                    check({nm[c], "_extra_beat"}, PW'(1), PW'(0));
                end else begin
                    check({nm[c], "_data"}, dut_d[c], exp_q[c].pop_front());
                    t = ts_q[c].pop_front();
                    if (chk_lat) check({nm[c], "_latency"}, PW'(cyc - t), PW'(lat_of(c)));
                end
            end
            held_v[c] = dut_v[c] && !sink_r[c];
            held_d[c] = dut_d[c];
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // sources keep an unaccepted beat; otherwise draw a new one
    task automatic drive_rand(int pv, int pr);
        for (int c = 0; c < 5; c++) begin
            if (!src_v[c] || fin[c]) begin
                src_v[c] = $urandom_range(99) < pv;
                src_d[c] = rnd_pl(c);
            end
            sink_r[c] = $urandom_range(99) < pr;
        end
    endtask

    task automatic set_all(logic v, logic r);
        for (int c = 0; c < 5; c++) begin
            src_v[c]  = v;
            sink_r[c] = r;
            fin[c]    = 1'b0;
        end
    endtask

    task automatic drain_and_check(string tag);
        set_all(1'b0, 1'b1);
        for (int k = 0; k < 3 * N + 4; k++) step();
        for (int c = 0; c < 5; c++) check({nm[c], "_", tag, "_empty"}, PW'(exp_q[c].size()), PW'(0));
    endtask

    // readys low during reset and exactly one edge after release, high after that edge
    task automatic release_reset();
        @(negedge clk);
        areset = 1'b0;
        set_all(1'b0, 1'b1);
        #1;
        for (int c = 0; c < 5; c++) if (MD[c] != BYP) check({nm[c], "_rdy_pre_edge"}, PW'(dut_r[c]), PW'(0));
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int c = 0; c < 5; c++) if (MD[c] != BYP) check({nm[c], "_rdy_post_edge"}, PW'(dut_r[c]), PW'(1));
    endtask

    initial begin
        int i;
        areset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            src_d[c] = '0; held_v[c] = 1'b0; held_d[c] = '0; acc[c] = 0; out_n[c] = 0;
        end
        set_all(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        for (int c = 0; c < 5; c++) begin
            check({nm[c], "_rst_valid"}, PW'(dut_v[c]), PW'(0));
            check({nm[c], "_rst_ready"}, PW'(dut_r[c]), PW'(0));
        end
        release_reset();

        // 64-beat W burst at full rate: no stall, fixed latency, order kept
        @(negedge clk);
        chk_lat = 1'b1;
        set_all(1'b0, 1'b0);
        sink_r[1] = 1'b1;
        for (int k = 0; k < 64; k++) begin
            src_v[1] = 1'b1;
            src_d[1] = PW'({DB'(k), 8'hFF, 1'(k == 63)});
            step();
            check("w_burst_ready", PW'(last_r[1]), PW'(1));
        end
        drain_and_check("burst");
        check("w_burst_count", PW'(out_n[1]), PW'(64));

        // 8 back-to-back AR requests through LIGHT stages: ready alternates, 1 per 2 cycles
        set_all(1'b0, 1'b0);
        sink_r[3] = 1'b1;
        out_n[3] = 0;
        i = 0;
        for (int k = 0; k < 17; k++) begin
            src_v[3] = i < 8;
            src_d[3] = PW'({IB'(0), AB'(32'h1000 + 32'h40 * i), 29'd0});
            step();
            if (k < 15) check("ar_ready_alt", PW'(last_r[3]), PW'(k % 2 == 0));
            if (fin[3]) i++;
        end
        check("ar_out_count", PW'(out_n[3]), PW'(8));
        chk_lat = 1'b0;
        drain_and_check("light");

        // downstream stalled: each channel holds exactly its slice capacity
        for (int c = 0; c < 5; c++) acc[c] = 0;
        set_all(1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < 5; c++) if (!src_v[c] || fin[c]) begin
                src_v[c] = 1'b1;
                src_d[c] = rnd_pl(c);
            end
            step();
        end
        for (int c = 0; c < 5; c++) check({nm[c], "_capacity"}, PW'(acc[c]), PW'(cap_of(c)));
        drain_and_check("cap");

        // random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            drive_rand(70, 50);
            step();
        end
        drain_and_check("rand1");

        // store a couple of beats, then reset asynchronously in mid-cycle
        set_all(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) src_d[c] = rnd_pl(c);
        step();
        step();
        #2;
        areset = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) if (MD[c] != BYP) begin
            check({nm[c], "_async_valid"}, PW'(dut_v[c]), PW'(0));
            check({nm[c], "_async_ready"}, PW'(dut_r[c]), PW'(0));
        end
        for (int c = 0; c < 5; c++) begin
            exp_q[c].delete();
            ts_q[c].delete();
            held_v[c] = 1'b0;
        end
        set_all(1'b0, 1'b0);
        release_reset();
        drain_and_check("stale");

        for (int k = 0; k < 400; k++) begin
            drive_rand(60, 70);
            step();
        end
        drain_and_check("rand2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
